// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and elaboration helpers for the digit-serial adder.
//   state_t        : controller states IDLE -> ADD -> DONE (2-bit encoding)
//   calcSteps()    : number of ADD cycles for a WIDTH/DIGIT pair
//   calcCntWidth() : step counter width, never narrower than one bit
// No ports (package).
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Guard against DIGIT=0 so a bad parameter set reaches the
    // elaboration check instead of dividing by zero.
    function automatic int calcSteps(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

    // A single-step configuration still needs a one-bit counter.
    function automatic int calcCntWidth(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// ---------------------------------------------------------------------------
// adder_digit
// Combinational DIGIT-bit ripple-carry adder used once per ADD cycle.
// Ports:
//   a, b   in  DIGIT  operand digits
//   cin    in  1      carry into bit 0 of the digit
//   s      out DIGIT  digit sum
//   cout   out 1      carry out of the digit's top bit
//   c_msb  out 1      carry into the digit's top bit (for signed overflow)
// ---------------------------------------------------------------------------
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic w_c;

    // Ripple through the digit; c_msb ends up holding the carry that
    // entered the last bit position.
    always_comb begin
        w_c   = cin;
        s     = '0;
        c_msb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]  = a[i] ^ b[i] ^ w_c;
            c_msb = w_c;
            w_c   = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        cout = w_c;
    end

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder: {Carry_out,Sum} = A + B + Carry_in, DIGIT bits per clock,
// with the inter-digit carry held in a register. valid/ready on both sides.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the Overflow port
// (signed overflow of the result).
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand set valid
//   in_ready   out  1      high only in IDLE
//   A, B       in   WIDTH  operands
//   Carry_in   in   1      carry into bit 0
//   out_valid  out  1      high only in DONE
//   out_ready  in   1      consumer accepts result
//   Sum        out  WIDTH  result, held until the next result
//   Carry_out  out  1      carry out of bit WIDTH-1
//   busy       out  1      state != IDLE
//   Overflow   out  1      (SERIAL_ADDER_OVERFLOW_EN only) signed overflow
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out,
    output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int STEPS = calcSteps(WIDTH, DIGIT);
    localparam int CNT_W = calcCntWidth(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParam
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sumShift;
    logic [WIDTH-1:0] r_sum;
    logic             r_carryOut;
    logic [DIGIT-1:0] w_digitSum;
    logic             w_digitCout;
    logic             w_digitCmsb;
    logic [WIDTH-1:0] w_sumShiftNext;

    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (r_opA[DIGIT-1:0]),
        .b     (r_opB[DIGIT-1:0]),
        .cin   (r_carry),
        .s     (w_digitSum),
        .cout  (w_digitCout),
        .c_msb (w_digitCmsb)
    );

    // New digit enters at the MSB end; after STEPS shifts the first digit
    // has reached bit 0. Written with shifts so DIGIT==WIDTH needs no
    // special case.
    assign w_sumShiftNext = (r_sumShift >> DIGIT)
                          | (WIDTH'(w_digitSum) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_nextState = ADD;
                end
            end
            ADD: begin
                if (r_cnt == LAST) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one digit per ADD cycle, publish the
    // result only on the final step so Sum stays stable otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sumShift <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opA      <= A;
                        r_opB      <= B;
                        r_carry    <= Carry_in;
                        r_cnt      <= '0;
                        r_sumShift <= '0;
                    end
                end
                ADD: begin
                    r_opA      <= r_opA >> DIGIT;
                    r_opB      <= r_opB >> DIGIT;
                    r_carry    <= w_digitCout;
                    r_sumShift <= w_sumShiftNext;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum      <= w_sumShiftNext;
                        r_carryOut <= w_digitCout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Sum       = r_sum;
    assign Carry_out = r_carryOut;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_overflow;

    // The last digit holds bit WIDTH-1, so its c_msb is the carry into
    // the sign bit; signed overflow is that carry differing from Carry_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_state == ADD && r_cnt == LAST) begin
            r_overflow <= w_digitCmsb ^ w_digitCout;
        end
    end

    assign Overflow = r_overflow;
`else
    // The carry into the top bit only matters for Overflow.
    logic w_unusedCmsb;
    assign w_unusedCmsb = w_digitCmsb;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder. Six instances cover W=8 (D=1,4) and
// W=16 (D=1,2,4,16); they share clock, reset, operand buses and out_ready,
// and each has its own in_valid so only one works at a time.
// Overflow is checked when SERIAL_ADDER_OVERFLOW_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int NCFG = 6;

    function automatic int cfgW(input int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic int cfgD(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            2:       return 1;
            3:       return 2;
            4:       return 4;
            default: return 16;
        endcase
    endfunction

    logic            clk;
    logic            rst_n;
    logic [15:0]     aBus;
    logic [15:0]     bBus;
    logic            cinBus;
    logic            outReady;
    logic [NCFG-1:0] inValid;
    logic [NCFG-1:0] inReady;
    logic [NCFG-1:0] outValid;
    logic [NCFG-1:0] busyV;
    logic [NCFG-1:0] coutV;
    logic [NCFG-1:0] ovfV;
    logic [15:0]     sumOut [NCFG];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = cfgW(g);
        localparam int D = cfgD(g);
        logic [W-1:0] sumG;
        logic         ovfG;

        serial_adder #(
            .WIDTH (W),
            .DIGIT (D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .A         (aBus[W-1:0]),
            .B         (bBus[W-1:0]),
            .Carry_in  (cinBus),
            .out_valid (outValid[g]),
            .out_ready (outReady),
            .Sum       (sumG),
            .Carry_out (coutV[g]),
            .busy      (busyV[g])
`ifdef SERIAL_ADDER_OVERFLOW_EN
            ,
            .Overflow  (ovfG)
`endif
        );
`ifndef SERIAL_ADDER_OVERFLOW_EN
        assign ovfG = 1'b0;
`endif
        assign sumOut[g] = 16'(sumG);
        assign ovfV[g]   = ovfG;
    end

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction on instance k, checked against plain arithmetic.
    // hold = cycles of out_ready low in DONE; pulse = poke in_valid with
    // other operands while the add is running.
    task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input int hold, input bit pulse);
        int     w;
        int     steps;
        int     lat;
        bit     done;
        longint mask;
        longint full;
        longint expSum;
        longint expCout;
        longint sa;
        longint sb;
        longint ssum;
        bit     expOvf;

        w       = cfgW(k);
        steps   = w / cfgD(k);
        mask    = (longint'(1) << w) - 1;
        full    = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
        expSum  = full & mask;
        expCout = (full >> w) & 1;
        sa      = longint'(a) & mask;
        sb      = longint'(b) & mask;
        if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
        if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        ssum    = sa + sb + longint'(cin);
        expOvf  = (ssum > ((longint'(1) << (w - 1)) - 1)) || (ssum < -(longint'(1) << (w - 1)));

        @(negedge clk);
        checkOutput("idleInReady", 32'(inReady[k]), 32'd1);
        aBus       = a;
        bBus       = b;
        cinBus     = cin;
        outReady   = 1'b0;
        inValid[k] = 1'b1;
        @(posedge clk);
        #1;
        inValid[k] = 1'b0;
        if (pulse) begin
            aBus       = 16'h0055;
            bBus       = ~b;
            cinBus     = ~cin;
            inValid[k] = 1'b1;
        end

        lat  = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 2) inValid[k] = 1'b0;
            if (outValid[k]) done = 1'b1;
        end
        inValid[k] = 1'b0;
        if (!done) begin
            checkOutput("resultTimeout", 32'(lat), 32'(steps));
            return;
        end

        checkOutput("latency", 32'(lat), 32'(steps));
        checkOutput("sum", 32'(sumOut[k]), 32'(expSum));
        checkOutput("carryOut", 32'(coutV[k]), 32'(expCout));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput("overflow", 32'(ovfV[k]), 32'(expOvf));
`endif
        checkOutput("doneInReady", 32'(inReady[k]), 32'd0);
        checkOutput("doneBusy", 32'(busyV[k]), 32'd1);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(outValid[k]), 32'd1);
            checkOutput("holdSum", 32'(sumOut[k]), 32'(expSum));
            checkOutput("holdCarry", 32'(coutV[k]), 32'(expCout));
            checkOutput("holdInReady", 32'(inReady[k]), 32'd0);
        end

        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("releaseValid", 32'(outValid[k]), 32'd0);
        checkOutput("releaseInReady", 32'(inReady[k]), 32'd1);
        checkOutput("releaseBusy", 32'(busyV[k]), 32'd0);
        checkOutput("idleSumHeld", 32'(sumOut[k]), 32'(expSum));
    endtask

    initial begin
        rst_n    = 1'b0;
        aBus     = '0;
        bBus     = '0;
        cinBus   = 1'b0;
        outReady = 1'b0;
        inValid  = '0;

        // Reset state of every instance.
        #12;
        for (int k = 0; k < NCFG; k++) begin
            checkOutput("rstInReady", 32'(inReady[k]), 32'd1);
            checkOutput("rstOutValid", 32'(outValid[k]), 32'd0);
            checkOutput("rstBusy", 32'(busyV[k]), 32'd0);
            checkOutput("rstSum", 32'(sumOut[k]), 32'd0);
            checkOutput("rstCarry", 32'(coutV[k]), 32'd0);
            checkOutput("rstOvf", 32'(ovfV[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed: W=8 D=1 and D=4 corner cases");
        applyStimulus(0, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        applyStimulus(1, 16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        applyStimulus(1, 16'h007F, 16'h0001, 1'b0, 0, 1'b0);

        $display("[TB] directed: backpressure and ignored in_valid");
        applyStimulus(0, 16'h00A5, 16'h003C, 1'b1, 5, 1'b0);
        applyStimulus(0, 16'h0012, 16'h0034, 1'b0, 1, 1'b1);

        $display("[TB] directed: reset during ADD");
        applyStimulus(0, 16'h003C, 16'h0005, 1'b0, 0, 1'b0);
        @(negedge clk);
        aBus       = 16'h0099;
        bBus       = 16'h0011;
        cinBus     = 1'b1;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(outValid[0]), 32'd0);
        checkOutput("midRstSum", 32'(sumOut[0]), 32'd0);
        checkOutput("midRstCarry", 32'(coutV[0]), 32'd0);
        checkOutput("midRstInReady", 32'(inReady[0]), 32'd1);
        checkOutput("midRstBusy", 32'(busyV[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 16'h0080, 16'h0080, 1'b1, 0, 1'b0);

        $display("[TB] W=16 boundary values and random sweep");
        for (int k = 2; k < NCFG; k++) begin
            applyStimulus(k, 16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
            applyStimulus(k, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
            applyStimulus(k, 16'h8000, 16'h8000, 1'b0, 1, 1'b0);
            for (int n = 0; n < 250; n++) begin
                applyStimulus(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
